// File: rtl/amber48_pkg.sv
// Shared types and constants for the amber48 UART transmitter.
// Pure declarations; no timing or flow-control behaviour lives here.
package amber48_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    UART_PARITY_NONE,
    UART_PARITY_EVEN,
    UART_PARITY_ODD
  } uart_parity_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_e;

endpackage

// File: rtl/amber48_sync_fifo.sv
// Byte FIFO, first-word-fall-through: rdata shows the head entry with zero read latency.
// Pushes into a full FIFO and pops from an empty one are ignored (full/empty judged pre-edge).
module amber48_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/amber48_uart_tx.sv
// UART transmitter: FIFO-buffered bytes out as 8-bit frames; first start bit one cycle after the write.
// tx_ready_o drops at DEPTH-1 entries so a valid arriving one cycle after ready was sampled still fits.
module amber48_uart_tx
  import amber48_pkg::*;
#(
  parameter int           CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int           FIFO_DEPTH   = 8,
  parameter uart_parity_e PARITY       = UART_PARITY_NONE,
  parameter int           STOP_BITS    = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            tx_valid_i,
  input  logic [7:0]                      tx_data_i,
  output logic                            tx_ready_o,
  output logic                            tx_o,
  output logic                            busy_o,
  output logic                            overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  uart_tx_state_e state;
  logic [BW-1:0]  bit_cnt;
  logic [2:0]     bit_idx;
  logic           stop_idx;
  logic [7:0]     shift_q;
  logic           par_q;
  logic           tx_q;
  logic           overflow_q;

  logic [7:0]     fifo_rdata;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           bit_end;
  logic           frame_end;
  logic           pop;

  amber48_sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (tx_valid_i),
    .pop   (pop),
    .wdata (tx_data_i),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end   = (bit_cnt == BIT_LAST);
  assign frame_end = (state == STOP) && bit_end && (stop_idx == STOP_LAST);
  // Popping on the last stop cycle chains frames with no idle gap.
  assign pop       = !fifo_empty && ((state == IDLE) || frame_end);

  assign tx_o         = tx_q;
  assign busy_o       = !fifo_empty || (state != IDLE);
  assign overflow_o   = overflow_q;
  assign fifo_count_o = fifo_count;
  assign tx_ready_o   = (fifo_count <= CW'(FIFO_DEPTH - 2));

  always_ff @(posedge clk_i) begin
    if (rst_i)                          overflow_q <= 1'b0;
    else if (tx_valid_i && fifo_full)   overflow_q <= 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift_q <= fifo_rdata;
            par_q   <= (^fifo_rdata) ^ (PARITY == UART_PARITY_ODD);
            bit_cnt <= '0;
            tx_q    <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx_q    <= shift_q[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
              if (PARITY == UART_PARITY_NONE) begin
                stop_idx <= 1'b0;
                tx_q     <= 1'b1;
                state    <= STOP;
              end else begin
                tx_q  <= par_q;
                state <= amber48_pkg::PARITY;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        amber48_pkg::PARITY: begin
          if (bit_end) begin
            bit_cnt  <= '0;
            stop_idx <= 1'b0;
            tx_q     <= 1'b1;
            state    <= STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (stop_idx == STOP_LAST) begin
              if (pop) begin
                shift_q <= fifo_rdata;
                par_q   <= (^fifo_rdata) ^ (PARITY == UART_PARITY_ODD);
                tx_q    <= 1'b0;
                state   <= START;
              end else begin
                tx_q  <= 1'b1;
                state <= IDLE;
              end
            end else begin
              stop_idx <= stop_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          tx_q  <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amber48_uart_tx.sv
// Directed bench: three transmitter configurations, serial receiver feeding a byte scoreboard.
module tb_amber48_uart_tx;
  import amber48_pkg::*;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dat = '0;
  logic       vld_none = 1'b0, vld_even = 1'b0, vld_odd = 1'b0;
  logic       rdy_none, rdy_even, rdy_odd;
  logic       tx_none, tx_even, tx_odd;
  logic       busy_none, busy_even, busy_odd;
  logic       ovf_none, ovf_even, ovf_odd;
  logic [2:0] cnt_none, cnt_even, cnt_odd;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  bit         mon_en  = 1'b1;
  logic [7:0] sb [$];

  amber48_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(UART_PARITY_NONE), .STOP_BITS(1)) u_none (
    .clk_i(clk), .rst_i(rst), .tx_valid_i(vld_none), .tx_data_i(dat), .tx_ready_o(rdy_none),
    .tx_o(tx_none), .busy_o(busy_none), .overflow_o(ovf_none), .fifo_count_o(cnt_none));

  amber48_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(UART_PARITY_EVEN), .STOP_BITS(1)) u_even (
    .clk_i(clk), .rst_i(rst), .tx_valid_i(vld_even), .tx_data_i(dat), .tx_ready_o(rdy_even),
    .tx_o(tx_even), .busy_o(busy_even), .overflow_o(ovf_even), .fifo_count_o(cnt_even));

  amber48_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(UART_PARITY_ODD), .STOP_BITS(2)) u_odd (
    .clk_i(clk), .rst_i(rst), .tx_valid_i(vld_odd), .tx_data_i(dat), .tx_ready_o(rdy_odd),
    .tx_o(tx_odd), .busy_o(busy_odd), .overflow_o(ovf_odd), .fifo_count_o(cnt_odd));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-cycle write strobe into u_none; keep=1 queues the byte as expected line output.
  task automatic wr_none(input logic [7:0] d, input bit keep);
    vld_none = 1'b1;
    dat      = d;
    if (keep) sb.push_back(d);
    step(1);
    vld_none = 1'b0;
  endtask

  task automatic wait_idle_none(input string tag, input int limit);
    for (int i = 0; i < limit && busy_none; i++) step(1);
    chk(tag, busy_none, 1'b0);
  endtask

  // Receiver on u_none: samples mid-bit, checks stop bit, pops the scoreboard.
  initial begin
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (mon_en && tx_none === 1'b0) begin
        repeat (CPB + CPB/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          rx[i] = tx_none;
          if (i < 7) repeat (CPB) @(negedge clk);
        end
        repeat (CPB) @(negedge clk);
        chk("rx_stop_bit", tx_none, 1'b1);
        chk("rx_frame_expected", sb.size() != 0, 1'b1);
        if (sb.size() != 0) chk("rx_byte", rx, sb.pop_front());
      end
    end
  end

  initial begin
    logic [9:0] pat;
    int         c0;
    int         lows;

    // Reset state of all three configurations
    step(3);
    chk("rst_tx_none", tx_none, 1'b1);
    chk("rst_busy_none", busy_none, 1'b0);
    chk("rst_ovf_none", ovf_none, 1'b0);
    chk("rst_cnt_none", cnt_none, 3'd0);
    chk("rst_rdy_none", rdy_none, 1'b1);
    chk("rst_all_even", {tx_even, busy_even, ovf_even, cnt_even, rdy_even}, 7'b1000001);
    chk("rst_all_odd", {tx_odd, busy_odd, ovf_odd, cnt_odd, rdy_odd}, 7'b1000001);
    rst = 1'b0;
    step(2);

    // 1: single 0x55 frame, no parity
    wr_none(8'h55, 1'b1);
    chk("t1_tx_idle_at_write", tx_none, 1'b1);
    chk("t1_cnt_after_write", cnt_none, 3'd1);
    step(1);
    pat = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t1_line_bit%0d", k), tx_none, pat[k]);
      if (k < 9) step(CPB);
    end
    step(3);
    chk("t1_busy_last_cycle", busy_none, 1'b1);
    step(1);
    chk("t1_busy_fall", busy_none, 1'b0);
    chk("t1_tx_idle", tx_none, 1'b1);

    // 2: parity variants, odd instance has two stop bits
    vld_even = 1'b1; vld_odd = 1'b1; dat = 8'h07;
    step(1);
    vld_even = 1'b0; vld_odd = 1'b0;
    step(1);
    chk("t2_start_even", tx_even, 1'b0);
    chk("t2_start_odd", tx_odd, 1'b0);
    step(CPB);
    chk("t2_bit0_even", tx_even, 1'b1);
    step(8 * CPB);
    chk("t2_parity_even", tx_even, 1'b1);
    chk("t2_parity_odd", tx_odd, 1'b0);
    step(CPB);
    chk("t2_stop_even", tx_even, 1'b1);
    chk("t2_stop_odd", tx_odd, 1'b1);
    step(3);
    chk("t2_busy_even_43", busy_even, 1'b1);
    step(1);
    chk("t2_busy_even_44", busy_even, 1'b0);
    chk("t2_busy_odd_44", busy_odd, 1'b1);
    chk("t2_stop2_odd", tx_odd, 1'b1);
    step(3);
    chk("t2_busy_odd_47", busy_odd, 1'b1);
    step(1);
    chk("t2_busy_odd_48", busy_odd, 1'b0);

    // 3: four writes every other cycle, frames back to back
    wr_none(8'h01, 1'b1);
    c0 = cyc;
    step(1);
    wr_none(8'h02, 1'b1);
    step(1);
    wr_none(8'h03, 1'b1);
    chk("t3_cnt2", cnt_none, 3'd2);
    chk("t3_rdy_at2", rdy_none, 1'b1);
    step(1);
    wr_none(8'h04, 1'b1);
    chk("t3_cnt3", cnt_none, 3'd3);
    chk("t3_rdy_at3", rdy_none, 1'b0);
    wait_idle_none("t3_idle_timeout", 400);
    chk("t3_total_cycles", cyc - c0, 32'd161);
    chk("t3_ovf", ovf_none, 1'b0);
    chk("t3_sb_drained", sb.size(), 32'd0);

    // 4: overflow while a frame is in flight
    wr_none(8'h10, 1'b1);
    step(1);
    wr_none(8'h20, 1'b1);
    wr_none(8'h30, 1'b1);
    wr_none(8'h40, 1'b1);
    wr_none(8'h50, 1'b1);
    chk("t4_cnt_full", cnt_none, 3'd4);
    chk("t4_ovf_before", ovf_none, 1'b0);
    wr_none(8'hAA, 1'b0);
    chk("t4_cnt_after_drop", cnt_none, 3'd4);
    chk("t4_ovf_set", ovf_none, 1'b1);
    step(20);
    chk("t4_ovf_sticky", ovf_none, 1'b1);
    wait_idle_none("t4_idle_timeout", 400);
    chk("t4_ovf_end", ovf_none, 1'b1);
    chk("t4_sb_drained", sb.size(), 32'd0);

    // 5: reset during data bit 3 of 0xF0
    mon_en = 1'b0;
    wr_none(8'hF0, 1'b0);
    step(1);
    chk("t5_start", tx_none, 1'b0);
    step(CPB + 3 * CPB);
    chk("t5_bit3", tx_none, 1'b0);
    rst = 1'b1; vld_none = 1'b1; dat = 8'h99;
    step(1);
    rst = 1'b0; vld_none = 1'b0;
    chk("t5_tx", tx_none, 1'b1);
    chk("t5_cnt", cnt_none, 3'd0);
    chk("t5_busy", busy_none, 1'b0);
    chk("t5_ovf_cleared", ovf_none, 1'b0);
    chk("t5_rdy", rdy_none, 1'b1);
    lows = 0;
    repeat (60) begin
      step(1);
      if (tx_none !== 1'b1) lows++;
    end
    chk("t5_line_quiet", lows, 32'd0);
    chk("t5_cnt_quiet", cnt_none, 3'd0);

    // 6: push and pop on the same edge with two entries queued
    mon_en = 1'b1;
    wr_none(8'h11, 1'b1);
    step(1);
    wr_none(8'h22, 1'b1);
    wr_none(8'h33, 1'b1);
    chk("t6_cnt2", cnt_none, 3'd2);
    step(37);
    chk("t6_stop_final", tx_none, 1'b1);
    wr_none(8'h44, 1'b1);
    chk("t6_cnt_same_edge", cnt_none, 3'd2);
    chk("t6_next_start", tx_none, 1'b0);
    wait_idle_none("t6_idle_timeout", 600);
    chk("t6_sb_drained", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
